// File: rtl/encoder32_rr.sv
// Round-robin 32-to-5 request encoder: sticky pending set, one index offered at a
// time on a valid/ready handshake, search starting just after the last grant.
module encoder32_rr #(
    parameter logic [4:0] PTR_INIT = 5'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req,
    output logic [31:0] pending,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pending_r;
    logic [31:0] pending_s;
    logic [31:0] clr_s;
    logic [4:0]  ptr_r;
    logic [4:0]  ptr_s;
    logic [4:0]  idx_r;
    logic [4:0]  idx_s;
    logic        valid_r;
    logic        valid_s;
    logic [5:0]  pick_res_s;
    logic [4:0]  pick_s;
    logic        any_s;
    logic        hs_s;

    // Returns {found, index} of the first set bit scanning start, start+1, ... modulo 32.
    function automatic logic [5:0] rr_pick(input logic [31:0] vec, input logic [4:0] start);
        logic [5:0] res;
        logic [4:0] pos;
        res = 6'd0;
        for (int i = 31; i >= 0; i--) begin
            pos = start + 5'(i);
            if (vec[pos]) begin
                res = {1'b1, pos};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Round-robin pick from registered state only, plus handshake detect.
    always_comb begin
        pick_res_s = rr_pick(pending_r, ptr_r);
        any_s      = pick_res_s[5];
        pick_s     = pick_res_s[4:0];
        hs_s       = valid_r & out_ready;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_s = OFFER;
                end else begin
                    state_s = IDLE;
                end
            end
            OFFER: begin
                if (hs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = OFFER;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM output logic: next values of the offer registers, pointer and clear mask.
    always_comb begin
        clr_s   = 32'd0;
        ptr_s   = ptr_r;
        idx_s   = idx_r;
        valid_s = valid_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    idx_s   = pick_s;
                    valid_s = 1'b1;
                end else begin
                    valid_s = 1'b0;
                end
            end
            OFFER: begin
                if (hs_s) begin
                    clr_s   = 32'd1 << idx_r;
                    ptr_s   = idx_r + 5'd1;
                    valid_s = 1'b0;
                end else begin
                    valid_s = 1'b1;
                end
            end
            default: begin
                valid_s = 1'b0;
            end
        endcase
    end

    // Set wins over clear so a re-raised request is never lost.
    always_comb begin
        pending_s = (pending_r & ~clr_s) | req;
    end

    // Datapath registers feeding the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 32'd0;
            ptr_r     <= PTR_INIT;
            idx_r     <= 5'd0;
            valid_r   <= 1'b0;
        end else begin
            pending_r <= pending_s;
            ptr_r     <= ptr_s;
            idx_r     <= idx_s;
            valid_r   <= valid_s;
        end
    end

    assign pending   = pending_r;
    assign out_valid = valid_r;
    assign out_idx   = idx_r;

endmodule

// File: doc/encoder32_rr.md
# encoder32_rr

Round-robin 32-to-5 request encoder, the inverse of the processor's 5-to-32 one-hot decoders. It latches up to 32 request lines into a sticky pending register and offers the 5-bit index of one pending request at a time on a valid/ready handshake. Selection is round-robin, starting just after the last granted index. Used wherever 32 sources (interrupt lines, register-scoreboard releases) must be serialised onto one 5-bit index bus.

## Interface
- PTR_INIT, 5'd0, round-robin search start index after reset.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  32  request lines; each high bit sets the matching pending bit on the next edge (pulse or level).
- pending  output  32  registered sticky pending set.
- out_valid  output  1  registered; out_idx holds a granted pending index.
- out_ready  input  1  consumer accepts out_idx when high with out_valid.
- out_idx  output  5  registered index of the offered request.

## Operation
- Reset state: pending=0, out_valid=0, out_idx=0, ptr=PTR_INIT, FSM=IDLE. Asserting rst_n low mid-offer clears all state immediately; no grant completes.
- Pending update, every edge: pending_next = (pending & ~clr) | req.
  - clr is one-hot at out_idx only in a handshake cycle (out_valid & out_ready); otherwise it is 0.
  - Set wins over clear: if req[out_idx] is high in the handshake cycle, the bit stays 1.
- Round-robin pick, combinational from registered pending and ptr: the first set bit scanning ptr, ptr+1, …, 31, 0, …, ptr-1, with modulo-32 wrap.
- FSM IDLE:
  - If pending != 0, on the edge: out_idx <= pick, out_valid <= 1, go OFFER.
  - Else stay IDLE with out_valid=0.
  - req bits arriving in this cycle are not visible to pick until the next cycle.
- FSM OFFER:
  - out_idx and out_valid are held stable while out_ready=0. New requests only accumulate in pending.
  - On handshake: clear pending[out_idx] (subject to set-wins), ptr <= out_idx+1 (31 wraps to 0), out_valid <= 0, go IDLE.
- Consequences:
  - At most one grant per 2 cycles.
  - An index is never offered twice for one pending assertion.
  - Every pending bit is granted within 32 handshakes (no starvation).
- out_idx retains its last value while out_valid=0. Consumers must ignore it.

## Timing
- Request-to-offer latency:
  - req bit high at edge E0 sets pending at E0.
  - If FSM is IDLE, out_valid=1 with that index after E1.
  - Minimum latency is 2 edges.
- Handshake is sampled at the edge where out_valid & out_ready are both high (Ek). After Ek: out_valid=0, pending bit cleared, ptr updated.
- The earliest next offer is after Ek+1.
- out_ready may be held high permanently. The sustained rate is then one index per 2 cycles.
- out_ready high while out_valid=0 has no effect.
- Simultaneous req and clear on the same bit: the bit stays set and is re-offered, but only after the pick has rotated past all other pending bits.
- No combinational path from req or out_ready to any output.

## Test plan
- Reset: rst_n low asynchronously mid-offer (out_valid=1, out_idx=9, pending=0x200) -> pending=0, out_valid=0, out_idx=0 immediately, without waiting for clk. After release, ptr=0, so a req[0] pulse is offered as index 0.
- Single request: req=0x20 for one cycle, out_ready=1 -> out_valid=1, out_idx=5 for exactly one cycle, 2 edges after the req edge. Then pending=0 and out_valid=0.
- Ordering and wrap: req=0x8000_0011 for one cycle, out_ready=1, ptr=0 -> grants 4 (ptr 0..4 scans to bit 4 first? no: bit 0 first), so the sequence is 0, 4, 31 on alternating cycles. Final ptr=0, pending=0.
- Round-robin wrap: after granting 5 (ptr=6), pending=0x8000_0004 -> grants 31, then 2.
- Backpressure: index 3 offered, out_ready=0 for 5 cycles, req[1] pulsed during the stall -> out_idx stays 3 and out_valid stays 1. pending=0x0A during the stall. After out_ready=1, the next grant is 1.
- Set-wins: req[3] high in the handshake cycle for index 3, other pending=0 -> pending[3] stays 1 and index 3 is offered again 2 edges later.
